// File: rtl/decode_stage.sv
// RV32I instruction-decode stage.
// Reads the register file (with same-edge writeback bypass), builds the
// sign-extended immediate and control bits, detects load-use hazards and
// owns the ID/EX register behind a valid/ready handshake.
// DATA_WIDTH is expected to be >= 32; immediates are sign-extended to it.
module decode_stage #(
  parameter int  DATA_WIDTH = 32,
  parameter int  REG_COUNT  = 32,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [31:0]           if_instr_i,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  output logic                  rf_read_en_o,
  output logic [AW-1:0]         rf_raddr1_o,
  output logic [AW-1:0]         rf_raddr2_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata1_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata2_i,
  input  logic                  wb_we_i,
  input  logic [AW-1:0]         wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
  output logic [DATA_WIDTH-1:0] ex_imm_o,
  output logic [AW-1:0]         ex_rs1_o,
  output logic [AW-1:0]         ex_rs2_o,
  output logic [AW-1:0]         ex_rd_o,
  output logic [6:0]            ex_opcode_o,
  output logic [2:0]            ex_funct3_o,
  output logic                  ex_funct7b5_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_illegal_o,
  output logic [31:0]           stall_cnt_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  // Writeback bypass: x0 reads zero, a same-edge write wins over the array.
  function automatic logic [DATA_WIDTH-1:0] sel_operand(
    input logic [AW-1:0]         idx,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  we,
    input logic [AW-1:0]         waddr,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] res;
    if (idx == {AW{1'b0}}) begin
      res = {DATA_WIDTH{1'b0}};
    end else if (we && (waddr == idx)) begin
      res = wdata;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  // Instruction fields
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        funct7b5_s;
  logic [4:0]  rd_field_s;
  logic [AW-1:0] rs1_s;
  logic [AW-1:0] rs2_s;
  logic [AW-1:0] rd_s;

  assign opcode_s   = if_instr_i[6:0];
  assign funct3_s   = if_instr_i[14:12];
  assign funct7b5_s = if_instr_i[30];
  assign rd_field_s = if_instr_i[11:7];
  assign rs1_s      = AW'(if_instr_i[19:15]);
  assign rs2_s      = AW'(if_instr_i[24:20]);
  assign rd_s       = AW'(if_instr_i[11:7]);

  // Raw 32-bit immediates per format; sign bit is always instr[31]
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

  assign imm_i_s = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
  assign imm_s_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
  assign imm_b_s = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                    if_instr_i[30:25], if_instr_i[11:8], 1'b0};
  assign imm_u_s = {if_instr_i[31:12], 12'd0};
  assign imm_j_s = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                    if_instr_i[20], if_instr_i[30:21], 1'b0};

  logic [31:0]           imm32_s;
  logic [DATA_WIDTH-1:0] imm_s;
  logic                  reg_write_s;
  logic                  mem_read_s;
  logic                  mem_write_s;
  logic                  illegal_s;
  logic                  rs1_used_s;
  logic                  rs2_used_s;

  // Opcode decode: immediate format, control bits and source-register usage
  always_comb begin
    imm32_s     = 32'd0;
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    illegal_s   = 1'b0;
    rs1_used_s  = 1'b1;
    rs2_used_s  = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        imm32_s     = imm_u_s;
        reg_write_s = 1'b1;
        rs1_used_s  = 1'b0;
      end
      OPC_AUIPC: begin
        imm32_s     = imm_u_s;
        reg_write_s = 1'b1;
        rs1_used_s  = 1'b0;
      end
      OPC_JAL: begin
        imm32_s     = imm_j_s;
        reg_write_s = 1'b1;
        rs1_used_s  = 1'b0;
      end
      OPC_JALR: begin
        imm32_s     = imm_i_s;
        reg_write_s = 1'b1;
      end
      OPC_BRANCH: begin
        imm32_s    = imm_b_s;
        rs2_used_s = 1'b1;
      end
      OPC_LOAD: begin
        imm32_s     = imm_i_s;
        reg_write_s = 1'b1;
        mem_read_s  = 1'b1;
      end
      OPC_STORE: begin
        imm32_s     = imm_s_s;
        mem_write_s = 1'b1;
        rs2_used_s  = 1'b1;
      end
      OPC_OPIMM: begin
        imm32_s     = imm_i_s;
        reg_write_s = 1'b1;
      end
      OPC_OP: begin
        imm32_s     = 32'd0;
        reg_write_s = 1'b1;
        rs2_used_s  = 1'b1;
      end
      default: begin
        // Unsupported opcode: no side effects, flows down as illegal
        imm32_s   = 32'd0;
        illegal_s = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded
    if (rd_field_s == 5'd0) begin
      reg_write_s = 1'b0;
    end else begin
      reg_write_s = reg_write_s;
    end
  end

  assign imm_s = DATA_WIDTH'($signed(imm32_s));

  // Register-file read ports
  assign rf_read_en_o = if_valid_i;
  assign rf_raddr1_o  = rs1_s;
  assign rf_raddr2_o  = rs2_s;

  logic [DATA_WIDTH-1:0] op1_s;
  logic [DATA_WIDTH-1:0] op2_s;

  assign op1_s = sel_operand(rs1_s, rf_rdata1_i, wb_we_i, wb_waddr_i, wb_wdata_i);
  assign op2_s = sel_operand(rs2_s, rf_rdata2_i, wb_we_i, wb_waddr_i, wb_wdata_i);

  // Handshake: ID/EX may load when empty or when EX is draining it
  logic adv_s;
  logic hazard_s;
  logic capture_s;

  assign adv_s = ex_ready_i | ~ex_valid_o;

  // Load-use hazard against the load currently sitting in ID/EX
  always_comb begin
    hazard_s = 1'b0;
    if (flush_i) begin
      hazard_s = 1'b0;
    end else if (if_valid_i && ex_valid_o && ex_mem_read_o && (ex_rd_o != {AW{1'b0}})) begin
      hazard_s = (rs1_used_s && (rs1_s == ex_rd_o)) ||
                 (rs2_used_s && (rs2_s == ex_rd_o));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // A flush consumes the incoming instruction, so IF may move on
  assign if_ready_o = flush_i | (adv_s & ~hazard_s);
  assign capture_s  = ~flush_i & adv_s & ~hazard_s & if_valid_i;

  // ID/EX valid flag and saturating load-use stall counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o  <= 1'b0;
      stall_cnt_o <= 32'd0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (adv_s && hazard_s) begin
      ex_valid_o <= 1'b0;
      if (stall_cnt_o != STALL_MAX) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end else if (adv_s) begin
      ex_valid_o <= if_valid_i;
    end
  end

  // ID/EX payload, loaded only when a valid instruction is accepted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_pc_o        <= {DATA_WIDTH{1'b0}};
      ex_rs1_data_o  <= {DATA_WIDTH{1'b0}};
      ex_rs2_data_o  <= {DATA_WIDTH{1'b0}};
      ex_imm_o       <= {DATA_WIDTH{1'b0}};
      ex_rs1_o       <= {AW{1'b0}};
      ex_rs2_o       <= {AW{1'b0}};
      ex_rd_o        <= {AW{1'b0}};
      ex_opcode_o    <= 7'd0;
      ex_funct3_o    <= 3'd0;
      ex_funct7b5_o  <= 1'b0;
      ex_reg_write_o <= 1'b0;
      ex_mem_read_o  <= 1'b0;
      ex_mem_write_o <= 1'b0;
      ex_illegal_o   <= 1'b0;
    end else if (capture_s) begin
      ex_pc_o        <= if_pc_i;
      ex_rs1_data_o  <= op1_s;
      ex_rs2_data_o  <= op2_s;
      ex_imm_o       <= imm_s;
      ex_rs1_o       <= rs1_s;
      ex_rs2_o       <= rs2_s;
      ex_rd_o        <= rd_s;
      ex_opcode_o    <= opcode_s;
      ex_funct3_o    <= funct3_s;
      ex_funct7b5_o  <= funct7b5_s;
      ex_reg_write_o <= reg_write_s;
      ex_mem_read_o  <= mem_read_s;
      ex_mem_write_o <= mem_write_s;
      ex_illegal_o   <= illegal_s;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// hazard/backpressure/reset sequences, and randomized traffic against a
// behavioural model of the stage.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        rf_read_en;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  decode_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(if_ready),
    .if_instr_i(if_instr), .if_pc_i(if_pc),
    .rf_read_en_o(rf_read_en), .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
    .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_pc_o(ex_pc), .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
    .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .ex_opcode_o(ex_opcode), .ex_funct3_o(ex_funct3), .ex_funct7b5_o(ex_funct7b5),
    .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read),
    .ex_mem_write_o(ex_mem_write), .ex_illegal_o(ex_illegal),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                         BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23,
                         OPIMM = 7'h13, OP = 7'h33;

  typedef struct {
    logic [31:0] imm;
    logic rw, mr, mw, ill, u1, u2;
  } dec_t;

  // Immediates computed arithmetically from the field weights
  function automatic dec_t decode_ref(input logic [31:0] ins);
    dec_t d;
    int sgn;
    sgn = ins[31] ? -1 : 0;
    d = '{imm: 32'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, ill: 1'b0, u1: 1'b1, u2: 1'b0};
    case (ins[6:0])
      LUI, AUIPC: begin d.imm = ins & 32'hFFFF_F000; d.rw = 1'b1; d.u1 = 1'b0; end
      JAL: begin
        d.imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        d.rw = 1'b1; d.u1 = 1'b0;
      end
      JALR, OPIMM: begin d.imm = sgn * 2048 + int'(ins[30:20]); d.rw = 1'b1; end
      LOAD: begin d.imm = sgn * 2048 + int'(ins[30:20]); d.rw = 1'b1; d.mr = 1'b1; end
      STORE: begin
        d.imm = sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        d.mw = 1'b1; d.u2 = 1'b1;
      end
      BRANCH: begin
        d.imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        d.u2 = 1'b1;
      end
      OP: begin d.rw = 1'b1; d.u2 = 1'b1; end
      default: d.ill = 1'b1;
    endcase
    if (ins[11:7] == 5'd0) d.rw = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] operand_ref(input logic [4:0] idx, input logic [31:0] rf,
                                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wa == idx) return wd;
    return rf;
  endfunction

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, rw, mr, mw, ill;
    logic [31:0] stall;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{valid: 1'b0, pc: 32'd0, rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0,
          rd: 5'd0, op: 7'd0, f3: 3'd0, f7: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, ill: 1'b0,
          stall: 32'd0};
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr, rf1, rf2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw, e_ill;
    logic [31:0] e_rs1d, e_rs2d;
  } vec_t;

  vec_t tbl[10];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = ins; if_pc = pc;
  endtask

  initial begin
    logic [6:0] ops[11];
    dec_t dd;
    logic adv, hz, rdy;

    tbl[0] = '{32'hFFF00293, 32'h12345678, 32'h0BADF00D, 1'b1, 5'd0, 32'hFFFF, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0BADF00D};
    tbl[1] = '{32'h000180B3, 32'h0, 32'h777, 1'b1, 5'd3, 32'hA5A5A5A5, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0};
    tbl[2] = '{32'h00012383, 32'h1000, 32'h2222, 1'b0, 5'd2, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h0};
    tbl[3] = '{32'hFE612E23, 32'h2000, 32'hDEADBEEF, 1'b1, 5'd6, 32'h55, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h55};
    tbl[4] = '{32'hFE208CE3, 32'h11, 32'h22, 1'b1, 5'd7, 32'h99, 32'hFFFFFFF8, 5'd25, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22};
    tbl[5] = '{32'hABCDE537, 32'h3, 32'h4, 1'b0, 5'd0, 32'h0, 32'hABCDE000, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3, 32'h4};
    tbl[6] = '{32'h001000EF, 32'h6, 32'h5, 1'b0, 5'd0, 32'h0, 32'h00000800, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5};
    tbl[7] = '{32'hFFFFFFFF, 32'h7, 32'h8, 1'b1, 5'd31, 32'hCAFEBABE, 32'h0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE, 32'hCAFEBABE};
    tbl[8] = '{32'h00100013, 32'h9, 32'hA, 1'b0, 5'd0, 32'h0, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hA};
    tbl[9] = '{32'h80000197, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h80000000, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, LOAD, STORE, OPIMM, OP, 7'h0B};

    rst = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0; wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    ex_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", ex_valid, 1'b0);
    check("rst_imm", ex_imm, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_ready", if_ready, 1'b1);

    // Load-use: lw x7,0(x2) then add x8,x7,x1
    drive(32'h00012383, 32'h40);
    @(negedge clk);
    check("lu_load_valid", ex_valid, 1'b1);
    drive(32'h00138433, 32'h44);
    #1;
    check("lu_ready_low", if_ready, 1'b0);
    @(negedge clk);
    check("lu_bubble", ex_valid, 1'b0);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    #1;
    check("lu_ready_back", if_ready, 1'b1);
    @(negedge clk);
    check("lu_dep_valid", ex_valid, 1'b1);
    check("lu_dep_rd", ex_rd, 5'd8);
    check("lu_dep_pc", ex_pc, 32'h44);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].instr, 32'h100 + 32'(i) * 32'd4);
      rf_rdata1 = tbl[i].rf1; rf_rdata2 = tbl[i].rf2;
      wb_we = tbl[i].we; wb_waddr = tbl[i].wa; wb_wdata = tbl[i].wd;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), ex_valid, 1'b1);
      check($sformatf("v%0d_imm", i), ex_imm, tbl[i].e_imm);
      check($sformatf("v%0d_rd", i), ex_rd, tbl[i].e_rd);
      check($sformatf("v%0d_ctrl", i), {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
            {tbl[i].e_rw, tbl[i].e_mr, tbl[i].e_mw, tbl[i].e_ill});
      check($sformatf("v%0d_rs1d", i), ex_rs1_data, tbl[i].e_rs1d);
      check($sformatf("v%0d_rs2d", i), ex_rs2_data, tbl[i].e_rs2d);
      check($sformatf("v%0d_opc", i), ex_opcode, tbl[i].instr & 32'h7F);
    end
    wb_we = 1'b0;

    // Backpressure for 3 cycles, then flush while EX still stalls
    drive(32'hFFF00293, 32'h400);
    @(negedge clk);
    check("bp_valid", ex_valid, 1'b1);
    ex_ready = 1'b0;
    drive(32'h00100013, 32'h500);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready_low", if_ready, 1'b0);
      @(negedge clk);
      check("bp_hold_valid", ex_valid, 1'b1);
      check("bp_hold_pc", ex_pc, 32'h400);
      check("bp_hold_imm", ex_imm, 32'hFFFFFFFF);
    end
    flush = 1'b1;
    #1;
    check("fl_ready", if_ready, 1'b1);
    @(negedge clk);
    check("fl_valid", ex_valid, 1'b0);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;

    // Randomized traffic against the model
    do_reset();
    m = mdl_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      check("r_valid", ex_valid, m.valid);
      check("r_pc", ex_pc, m.pc);
      check("r_rs1d", ex_rs1_data, m.rs1d);
      check("r_rs2d", ex_rs2_data, m.rs2d);
      check("r_imm", ex_imm, m.imm);
      check("r_fields", {ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5},
            {m.rs1, m.rs2, m.rd, m.op, m.f3, m.f7});
      check("r_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
            {m.rw, m.mr, m.mw, m.ill});
      check("r_stall", stall_cnt, m.stall);

      if_valid  = ($urandom_range(0, 3) != 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      if_instr  = $urandom();
      if_instr[6:0]   = ops[$urandom_range(0, 10)];
      if_instr[11:7]  = 5'($urandom_range(0, 7));
      if_instr[19:15] = 5'($urandom_range(0, 7));
      if_instr[24:20] = 5'($urandom_range(0, 7));
      if_pc     = $urandom();
      rf_rdata1 = $urandom();
      rf_rdata2 = $urandom();
      wb_we     = $urandom_range(0, 1) == 1;
      wb_waddr  = 5'($urandom_range(0, 7));
      wb_wdata  = $urandom();
      #1;

      dd  = decode_ref(if_instr);
      adv = ex_ready || !m.valid;
      hz  = !flush && if_valid && m.valid && m.mr && (m.rd != 5'd0) &&
            ((dd.u1 && if_instr[19:15] == m.rd) || (dd.u2 && if_instr[24:20] == m.rd));
      rdy = flush || (adv && !hz);
      check("r_if_ready", if_ready, rdy);
      check("r_rf_port", {rf_read_en, rf_raddr1, rf_raddr2}, {if_valid, if_instr[19:15], if_instr[24:20]});

      if (flush) begin
        m.valid = 1'b0;
      end else if (adv && hz) begin
        m.valid = 1'b0;
        if (m.stall != 32'hFFFF_FFFF) m.stall = m.stall + 32'd1;
      end else if (adv) begin
        m.valid = if_valid;
        if (if_valid) begin
          m.pc   = if_pc;
          m.rs1d = operand_ref(if_instr[19:15], rf_rdata1, wb_we, wb_waddr, wb_wdata);
          m.rs2d = operand_ref(if_instr[24:20], rf_rdata2, wb_we, wb_waddr, wb_wdata);
          m.imm  = dd.imm;
          m.rs1  = if_instr[19:15];
          m.rs2  = if_instr[24:20];
          m.rd   = if_instr[11:7];
          m.op   = if_instr[6:0];
          m.f3   = if_instr[14:12];
          m.f7   = if_instr[30];
          m.rw   = dd.rw; m.mr = dd.mr; m.mw = dd.mw; m.ill = dd.ill;
        end
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-stream, observed before the next clock edge
    flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0;
    drive(32'hFFF00293, 32'h600);
    @(negedge clk);
    check("ar_pre_valid", ex_valid, 1'b1);
    check("ar_pre_stall", stall_cnt, m.stall);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", ex_valid, 1'b0);
    check("ar_stall", stall_cnt, 32'd0);
    check("ar_imm", ex_imm, 32'd0);
    @(negedge clk);
    rst = 1'b0; if_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
